// File: rtl/pads_pkg.sv
// Shared types and helpers for the pad-control scratchpad bank.
package pads_pkg;

   // Request opcodes carried on req_op.
   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_WRITE = 2'd1,
      OP_FILL  = 2'd2,
      OP_CLEAR = 2'd3
   } pads_op_e;

   // Controller states: SWEEP zeroes entries, IDLE serves requests.
   typedef enum logic {
      ST_SWEEP = 1'b0,
      ST_IDLE  = 1'b1
   } pads_state_e;

   // Channel-select width; a single channel still needs one select bit.
   function automatic int pads_cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pads_chan_bank.sv
// One channel of the bank: data entries plus exists bits, a single write
// port and an asynchronous read port.
module pads_chan_bank #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     wr_en_i,
   input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     wr_set_i,
   input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     rd_hit_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0] exists_q;

   // Single write port: data and its exists flag update together.
   // No reset here; the controller's sweep zeroes every entry instead.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_idx_i]    <= wr_data_i;
         exists_q[wr_idx_i] <= wr_set_i;
      end
   end

   assign rd_data_o = mem_q[rd_idx_i];
   assign rd_hit_o  = exists_q[rd_idx_i];

endmodule

// File: rtl/pads_bank_array.sv
// Multi-channel scratchpad bank: request decode, range checks, sweep FSM
// and the registered read-response path.
module pads_bank_array
   import pads_pkg::*;
#(
   parameter int NCH        = 2,
   parameter int DEPTH      = 8,
   parameter int WIDTH      = 32,
   parameter int FILL_VALUE = 33
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [1:0]               req_op,
   input  logic [pads_cw(NCH)-1:0]  req_chan,
   input  logic [$clog2(DEPTH)-1:0] req_idx,
   input  logic [WIDTH-1:0]         req_wdata,
   output logic                     rsp_valid,
   output logic [WIDTH-1:0]         rsp_data,
   output logic                     rsp_hit,
   output logic [pads_cw(NCH)-1:0]  rsp_chan
);

   localparam int CW = pads_cw(NCH);
   localparam int IW = $clog2(DEPTH);

   pads_state_e   state_q, state_d;
   logic [IW-1:0] cnt_q, cnt_d;
   logic          all_q, all_d;
   logic [CW-1:0] chan_q, chan_d;

   logic             rsp_valid_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic             rsp_hit_q;
   logic [CW-1:0]    rsp_chan_q;

   pads_op_e op;
   logic     accept;
   logic     chan_ok;
   logic     idx_ok;
   logic     in_range;
   logic     sweeping;

   logic [WIDTH-1:0] rd_data_w [NCH];
   logic [NCH-1:0]   rd_hit_w;
   logic [WIDTH-1:0] sel_data;
   logic             sel_hit;

   assign op        = pads_op_e'(req_op);
   assign req_ready = (state_q == ST_IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign chan_ok   = (32'(req_chan) < 32'(NCH));
   assign idx_ok    = (32'(req_idx) < 32'(DEPTH));
   assign in_range  = chan_ok && idx_ok;
   assign sweeping  = (state_q == ST_SWEEP);

   // Per-channel storage; the sweep and request writes never coincide
   // because requests are only accepted in IDLE.
   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      logic sweep_wr;
      logic req_wr;

      assign sweep_wr = sweeping && (all_q || (chan_q == CW'(gi)));
      assign req_wr   = accept && in_range && (req_chan == CW'(gi)) &&
                        ((op == OP_WRITE) || (op == OP_FILL));

      pads_chan_bank #(
         .DEPTH (DEPTH),
         .WIDTH (WIDTH)
      ) u_bank (
         .clk       (clk),
         .wr_en_i   (sweep_wr || req_wr),
         .wr_idx_i  (sweep_wr ? cnt_q : req_idx),
         .wr_data_i (sweep_wr ? '0 :
                     ((op == OP_FILL) ? WIDTH'(FILL_VALUE) : req_wdata)),
         .wr_set_i  (!sweep_wr),
         .rd_idx_i  (req_idx),
         .rd_data_o (rd_data_w[gi]),
         .rd_hit_o  (rd_hit_w[gi])
      );
   end

   // Select the addressed channel's read port; out-of-range channels read as empty.
   always_comb begin
      sel_data = '0;
      sel_hit  = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (32'(req_chan) == 32'(i)) begin
            sel_data = rd_data_w[i];
            sel_hit  = rd_hit_w[i];
         end
      end
   end

   // Sweep/idle next-state: a sweep walks every index once, a CLEAR starts a single-channel sweep.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      all_d   = all_q;
      chan_d  = chan_q;
      if (state_q == ST_SWEEP) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == IW'(DEPTH - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      end else if (accept && (op == OP_CLEAR) && in_range) begin
         state_d = ST_SWEEP;
         cnt_d   = '0;
         all_d   = 1'b0;
         chan_d  = req_chan;
      end
   end

   // State register; reset restarts a full all-channel sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_SWEEP;
         cnt_q   <= '0;
         all_q   <= 1'b1;
         chan_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         all_q   <= all_d;
         chan_q  <= chan_d;
      end
   end

   // Read response: captures storage as seen at the accepting edge, one-cycle strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_hit_q   <= 1'b0;
         rsp_chan_q  <= '0;
      end else begin
         rsp_valid_q <= accept && (op == OP_READ);
         if (accept && (op == OP_READ)) begin
            rsp_hit_q  <= in_range && sel_hit;
            rsp_data_q <= (in_range && sel_hit) ? sel_data : '0;
            rsp_chan_q <= req_chan;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_hit   = rsp_hit_q;
   assign rsp_chan  = rsp_chan_q;

endmodule

// File: tb/tb_pads_bank_array.sv
// Directed bench for pads_bank_array with three channels of eight entries.
module tb_pads_bank_array;
   import pads_pkg::*;

   localparam int NCH   = 3;
   localparam int DEPTH = 8;
   localparam int WIDTH = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [1:0]        req_chan;
   logic [2:0]        req_idx;
   logic [WIDTH-1:0]  req_wdata;
   logic              rsp_valid;
   logic [WIDTH-1:0]  rsp_data;
   logic              rsp_hit;
   logic [1:0]        rsp_chan;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pads_bank_array #(
      .NCH        (NCH),
      .DEPTH      (DEPTH),
      .WIDTH      (WIDTH),
      .FILL_VALUE (33)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_chan  (req_chan),
      .req_idx   (req_idx),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_hit   (rsp_hit),
      .rsp_chan  (rsp_chan)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input pads_op_e op, input logic [1:0] ch,
                         input logic [2:0] idx, input logic [31:0] wd);
      check_eq("ready_before_req", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_chan  = ch;
      req_idx   = idx;
      req_wdata = wd;
      $display("req %s ch=%0d idx=%0d wdata=%0h", op.name(), ch, idx, wd);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [1:0] ch, input logic [2:0] idx,
                           input logic [31:0] exp_data, input logic exp_hit);
      do_req(OP_READ, ch, idx, 32'd0);
      check_eq({tag, "_valid"}, 64'(rsp_valid), 64'd1);
      check_eq({tag, "_data"},  64'(rsp_data),  64'(exp_data));
      check_eq({tag, "_hit"},   64'(rsp_hit),   64'(exp_hit));
      check_eq({tag, "_chan"},  64'(rsp_chan),  64'(ch));
   endtask

   // Count edges until req_ready rises, bounded.
   task automatic edges_to_ready(output int n);
      n = 0;
      while (!req_ready && n < 40) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = 2'd0;
      req_chan  = 2'd0;
      req_idx   = 3'd0;
      req_wdata = '0;

      // Reset held three cycles.
      repeat (3) tick();
      check_eq("rst_ready",     64'(req_ready), 64'd0);
      check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check_eq("rst_rsp_data",  64'(rsp_data),  64'd0);
      check_eq("rst_rsp_hit",   64'(rsp_hit),   64'd0);
      check_eq("rst_rsp_chan",  64'(rsp_chan),  64'd0);

      rst = 1'b0;
      edges_to_ready(n);
      check_eq("init_sweep_len", 64'(n), 64'd8);

      // Write then read back on the next accepted edge.
      do_req(OP_WRITE, 2'd0, 3'd3, 32'h1234);
      check_eq("write_no_rsp", 64'(rsp_valid), 64'd0);
      read_chk("rd_ch0_i3", 2'd0, 3'd3, 32'h1234, 1'b1);
      tick();
      check_eq("rsp_strobe_drop", 64'(rsp_valid), 64'd0);

      // Fill and channel independence.
      do_req(OP_FILL, 2'd1, 3'd3, 32'hffff_ffff);
      read_chk("rd_ch1_fill", 2'd1, 3'd3, 32'd33, 1'b1);
      read_chk("rd_ch0_i5_empty", 2'd0, 3'd5, 32'd0, 1'b0);
      read_chk("rd_ch2_i3_empty", 2'd2, 3'd3, 32'd0, 1'b0);
      do_req(OP_FILL, 2'd0, 3'd6, 32'd0);

      // Read immediately before CLEAR still responds; then ready low 8 cycles.
      read_chk("rd_before_clr", 2'd0, 3'd3, 32'h1234, 1'b1);
      do_req(OP_CLEAR, 2'd1, 3'd0, 32'd0);
      check_eq("clr_no_rsp", 64'(rsp_valid), 64'd0);
      n = 0;
      while (!req_ready && n < 40) begin
         n++;
         tick();
      end
      check_eq("clr_ready_low", 64'(n), 64'd8);
      read_chk("rd_ch1_cleared", 2'd1, 3'd3, 32'd0, 1'b0);
      read_chk("rd_ch0_kept",    2'd0, 3'd3, 32'h1234, 1'b1);
      read_chk("rd_ch0_fill",    2'd0, 3'd6, 32'd33, 1'b1);

      // Boundary entries on channel 2.
      do_req(OP_WRITE, 2'd2, 3'd7, 32'hcafe_0007);
      do_req(OP_WRITE, 2'd2, 3'd0, 32'hcafe_0000);
      read_chk("rd_ch2_i7", 2'd2, 3'd7, 32'hcafe_0007, 1'b1);
      read_chk("rd_ch2_i0", 2'd2, 3'd0, 32'hcafe_0000, 1'b1);

      // Out-of-range channel: accepted, changes nothing, reads empty.
      do_req(OP_WRITE, 2'd3, 3'd3, 32'hdead_beef);
      check_eq("oor_write_ready", 64'(req_ready), 64'd1);
      read_chk("rd_oor_ch3", 2'd3, 3'd3, 32'd0, 1'b0);
      read_chk("rd_after_oor", 2'd0, 3'd3, 32'h1234, 1'b1);
      do_req(OP_CLEAR, 2'd3, 3'd0, 32'd0);
      check_eq("oor_clear_ready", 64'(req_ready), 64'd1);

      // Reset in the middle of a CLEAR sweep restarts a full sweep.
      do_req(OP_CLEAR, 2'd0, 3'd0, 32'd0);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("midsweep_ready", 64'(req_ready), 64'd0);
      edges_to_ready(n);
      check_eq("midsweep_len", 64'(n), 64'd8);
      read_chk("post_rst_ch0_i3", 2'd0, 3'd3, 32'd0, 1'b0);
      read_chk("post_rst_ch0_i6", 2'd0, 3'd6, 32'd0, 1'b0);
      read_chk("post_rst_ch1_i3", 2'd1, 3'd3, 32'd0, 1'b0);
      read_chk("post_rst_ch2_i7", 2'd2, 3'd7, 32'd0, 1'b0);
      read_chk("post_rst_ch2_i0", 2'd2, 3'd0, 32'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
